axi_traffic_loader: RTL and testbench
=====================================

// Module: axi_traffic_loader
// PURPOSE
// - Per-core AXI4 traffic generator: the responder end of the host command port (req_depth/id/write/axlen/fifo_push/start/idle, pmu_addr/pmu_data).
// - Host pushes request descriptors into a FIFO, then pulses start.
// - Block issues descriptors as AXI bursts into the mesh, honouring an outstanding-transaction limit.
// - Reports idle when done; exposes performance counters on a PMU read port.
// PARAMETERS
// - AXI_ID_WIDTH  5   AXI ID width.
// - DATA_WIDTH    32  AXI data width (>= AXI_ID_WIDTH+8).
// - ADDR_WIDTH    16  AXI address width.
// - FIFO_DEPTH    16  descriptor FIFO entries (power of 2).
// - WQ_DEPTH      8   pending-W-burst queue entries (power of 2).
// PORTS
// - aclk          in   1           clock
// - aresetn       in   1           async active-low reset
// - req_depth_i   in   8           max outstanding transactions; 0 is treated as 1
// - id_i          in   AXI_ID_WIDTH  descriptor ID
// - write_i       in   1           descriptor type: 1=write, 0=read
// - axlen_i       in   8           descriptor AXI len (beats-1)
// - fifo_push_i   in   1           push {id,write,axlen} into FIFO
// - start_i       in   1           begin draining FIFO
// - idle_o        out  1           1 = no run in progress
// - pmu_addr_i    in   5           counter select
// - pmu_data_o    out  64          selected counter, combinational from pmu_addr_i
// - m_aw*/m_w*/m_b*/m_ar*/m_r*     AXI4 master channels: id, addr, len, size=log2(DATA_WIDTH/8), burst=INCR
// BEHAVIOUR
// Reset
// - All valids = 0; idle_o = 1; FIFO, W queue, outstanding count and counters = 0; m_bready = m_rready = 1.
// - Reset mid-run abandons all in-flight traffic; no completion is awaited.
// Push
// - fifo_push_i is accepted in any state.
// - Push while FIFO full: descriptor dropped, drop counter increments.
// FSM states
// - IDLE: start_i -> RUN; idle_o = 0 from the next cycle. start_i outside IDLE is ignored.
// - RUN: while FIFO not empty, issue the head descriptor.
//   - Issue requires outstanding < max(req_depth_i,1); for writes it also requires W queue not full.
//   - Write: m_awvalid with addr = {id, 8'h00} zero-extended/truncated to ADDR_WIDTH, len = axlen; push axlen to W queue on issue.
//   - Read: same scheme on m_arvalid.
//   - One descriptor in flight on AW/AR at a time. Valid holds until ready; pop and outstanding++ on the handshake.
//   - FIFO empty and no AW/AR pending -> DRAIN.
// - DRAIN: outstanding == 0 and W queue empty -> IDLE; idle_o = 1 in the same cycle the state becomes IDLE.
// - Start with empty FIFO: idle_o low for exactly 2 cycles.
// W channel (independent of FSM)
// - Serves the W queue head: beat data = {id, beat_idx[7:0]} zero-extended; wstrb all ones; wlast on beat == len.
// - Pop on the last-beat handshake.
// - W beats may precede AW acceptance; no W-before-AW dependency is required of the slave.
// Completion
// - B handshake and R handshake with rlast each decrement outstanding.
// - Both in one cycle: decrement by 2. Issue and completion in the same cycle: net change.
// - Outstanding counter never wraps: it is 9 bits, bounded by 255.
// PMU map
// - Counters 64-bit, saturating at all-ones. All except 11 clear on start acceptance.
// - 0 run cycles (idle_o=0)   1 AW issued      2 AR issued      3 W beats
// - 4 R beats                 5 B received     6 R bursts (rlast) 7 stall cycles (head valid, blocked by limit)
// - 8 error responses (bresp/rresp != OKAY; counted per B and per R beat)
// - 9,10: see CONFIGURATION   11 dropped pushes (cleared only by reset)   others read 0
// CONFIGURATION
// - LOADER_LATENCY_EN defined:
//   - addr 9 accumulates the outstanding count every RUN/DRAIN cycle (Little's-law integral; average latency = ctr9 / (ctr5 + ctr6)).
//   - addr 10 holds the peak outstanding count.
// - LOADER_LATENCY_EN undefined: addr 9 and addr 10 read 0; no accumulator logic is synthesised.
// TESTING
// - Push 1 read (id=3, len=3), start, slave ready=1, 1-cycle latency.
//   -> ARADDR=0x0300, ARLEN=3; 4 R beats; idle_o returns to 1; ctr2=1, ctr4=4, ctr6=1.
// - Push 1 write (id=2, len=1), start.
//   -> W data 0x0200, 0x0201 with wlast on the 2nd beat; after B, ctr1=1, ctr3=2, ctr5=1.
// - req_depth=2, 4 reads, slave withholds R for 20 cycles.
//   -> exactly 2 AR handshakes before the first R; ctr7 > 0; all 4 complete.
// - 17 pushes, FIFO_DEPTH=16 -> ctr11=1; start -> exactly 16 transactions issued.
// - Start with empty FIFO -> idle_o low 2 cycles.
//   - Start mid-run is ignored: no counter clear.
// - Assert aresetn low mid-burst -> all valids 0 and idle_o=1 asynchronously.
//   - With LOADER_LATENCY_EN, after the req_depth=2 test ctr10=2.

Source files
------------

// File: rtl/axi_traffic_loader.sv
// -----------------------------------------------------------------------------
// axi_traffic_loader
//
// Per-core AXI4 traffic generator. The host pushes request descriptors
// {id, write, axlen} into a FIFO and pulses start_i. The block then issues
// each descriptor as one AXI burst (AW or AR), never exceeding the
// outstanding-transaction limit. W data is generated from a pending-burst
// queue that is filled when a write is issued. Completions (B, R with rlast)
// retire outstanding transactions. Performance counters can be read on the
// PMU port.
//
// Optional feature macro: LOADER_LATENCY_EN
//   defined   : PMU addr 9 integrates the outstanding count every RUN/DRAIN
//               cycle, addr 10 holds the peak outstanding count.
//   undefined : PMU addr 9 and 10 read 0.
//
// Ports
//   aclk, aresetn         clock, asynchronous active-low reset
//   req_depth_i [7:0]     max outstanding transactions (0 behaves as 1)
//   id_i, write_i,
//   axlen_i, fifo_push_i  descriptor push interface
//   start_i               start draining the FIFO (accepted only when idle)
//   idle_o                1 when no run is in progress
//   pmu_addr_i [4:0]      counter select
//   pmu_data_o [63:0]     selected counter (combinational)
//   m_aw*/m_w*/m_b*/
//   m_ar*/m_r*            AXI4 master channels (INCR bursts, full-width beats)
// -----------------------------------------------------------------------------
module axi_traffic_loader #(
  parameter int AXI_ID_WIDTH = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int WQ_DEPTH     = 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [7:0]                req_depth_i,
  input  logic [AXI_ID_WIDTH-1:0]   id_i,
  input  logic                      write_i,
  input  logic [7:0]                axlen_i,
  input  logic                      fifo_push_i,
  input  logic                      start_i,
  output logic                      idle_o,
  input  logic [4:0]                pmu_addr_i,
  output logic [63:0]               pmu_data_o,
  // AW channel
  output logic [AXI_ID_WIDTH-1:0]   m_awid_o,
  output logic [ADDR_WIDTH-1:0]     m_awaddr_o,
  output logic [7:0]                m_awlen_o,
  output logic [2:0]                m_awsize_o,
  output logic [1:0]                m_awburst_o,
  output logic                      m_awvalid_o,
  input  logic                      m_awready_i,
  // W channel
  output logic [DATA_WIDTH-1:0]     m_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb_o,
  output logic                      m_wlast_o,
  output logic                      m_wvalid_o,
  input  logic                      m_wready_i,
  // B channel
  input  logic [AXI_ID_WIDTH-1:0]   m_bid_i,
  input  logic [1:0]                m_bresp_i,
  input  logic                      m_bvalid_i,
  output logic                      m_bready_o,
  // AR channel
  output logic [AXI_ID_WIDTH-1:0]   m_arid_o,
  output logic [ADDR_WIDTH-1:0]     m_araddr_o,
  output logic [7:0]                m_arlen_o,
  output logic [2:0]                m_arsize_o,
  output logic [1:0]                m_arburst_o,
  output logic                      m_arvalid_o,
  input  logic                      m_arready_i,
  // R channel
  input  logic [AXI_ID_WIDTH-1:0]   m_rid_i,
  input  logic [DATA_WIDTH-1:0]     m_rdata_i,
  input  logic [1:0]                m_rresp_i,
  input  logic                      m_rlast_i,
  input  logic                      m_rvalid_i,
  output logic                      m_rready_o
);

  localparam int DESC_W = AXI_ID_WIDTH + 9;
  localparam int WQ_W   = AXI_ID_WIDTH + 8;
  localparam int FA_W   = $clog2(FIFO_DEPTH);
  localparam int WA_W   = $clog2(WQ_DEPTH);
  localparam int NCTR   = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Saturating 64-bit add used by every PMU counter.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[64]) begin
      return {64{1'b1}};
    end else begin
      return s[63:0];
    end
  endfunction

  state_e state_q, state_d;
  logic   idle_q;

  // Descriptor FIFO
  logic [DESC_W-1:0]       fifo_mem_q [FIFO_DEPTH];
  logic [FA_W:0]           fifo_wr_q, fifo_rd_q;
  logic                    fifo_empty_s, fifo_full_s, push_ok_s, drop_s;
  logic [DESC_W-1:0]       head_s;
  logic [AXI_ID_WIDTH-1:0] head_id_s;
  logic                    head_wr_s;
  logic [7:0]              head_len_s;

  // Pending W-burst queue: {id, len}
  logic [WQ_W-1:0]         wq_mem_q [WQ_DEPTH];
  logic [WA_W:0]           wq_wr_q, wq_rd_q;
  logic                    wq_empty_s, wq_full_s, wq_push_s, wq_pop_s;
  logic [AXI_ID_WIDTH-1:0] wq_id_s;
  logic [7:0]              wq_len_s;
  logic [7:0]              beat_q;

  // Address channel registers
  logic                    aw_valid_q, ar_valid_q;
  logic [AXI_ID_WIDTH-1:0] aw_id_q, ar_id_q;
  logic [ADDR_WIDTH-1:0]   aw_addr_q, ar_addr_q;
  logic [7:0]              aw_len_q, ar_len_q;

  // Issue / completion
  logic [7:0]  limit_s;
  logic        room_s, pending_s, cand_s, issue_s, stall_s;
  logic        aw_hs_s, ar_hs_s, pop_s, w_hs_s, w_last_s;
  logic        b_hs_s, r_beat_s, r_done_s, b_err_s, r_err_s, start_acc_s;
  logic [8:0]  out_q, out_d;
  logic [9:0]  out_sum_s, out_dec_s, out_net_s;

  // PMU
  logic [63:0] ctr_q [NCTR];
  logic [63:0] ctr_d [NCTR];

  logic        unused_inputs_s;
  assign unused_inputs_s = ^{m_bid_i, m_rid_i, m_rdata_i};

  // ---------------------------------------------------------------------------
  // FIFO status and head decode
  // ---------------------------------------------------------------------------
  assign fifo_empty_s = (fifo_wr_q == fifo_rd_q);
  assign fifo_full_s  = (fifo_wr_q[FA_W] != fifo_rd_q[FA_W]) &&
                        (fifo_wr_q[FA_W-1:0] == fifo_rd_q[FA_W-1:0]);
  assign push_ok_s    = fifo_push_i && !fifo_full_s;
  assign drop_s       = fifo_push_i && fifo_full_s;
  assign head_s       = fifo_mem_q[fifo_rd_q[FA_W-1:0]];
  assign head_id_s    = head_s[DESC_W-1 -: AXI_ID_WIDTH];
  assign head_wr_s    = head_s[8];
  assign head_len_s   = head_s[7:0];

  assign wq_empty_s   = (wq_wr_q == wq_rd_q);
  assign wq_full_s    = (wq_wr_q[WA_W] != wq_rd_q[WA_W]) &&
                        (wq_wr_q[WA_W-1:0] == wq_rd_q[WA_W-1:0]);
  assign wq_id_s      = wq_mem_q[wq_rd_q[WA_W-1:0]][WQ_W-1 -: AXI_ID_WIDTH];
  assign wq_len_s     = wq_mem_q[wq_rd_q[WA_W-1:0]][7:0];

  // ---------------------------------------------------------------------------
  // Issue and handshake decode
  // ---------------------------------------------------------------------------
  assign limit_s     = (req_depth_i == 8'd0) ? 8'd1 : req_depth_i;
  assign room_s      = (out_q < {1'b0, limit_s});
  assign pending_s   = aw_valid_q || ar_valid_q;
  // A head descriptor is a candidate only when no AW/AR is already presented.
  assign cand_s      = (state_q == ST_RUN) && !fifo_empty_s && !pending_s;
  assign issue_s     = cand_s && room_s && (!head_wr_s || !wq_full_s);
  assign stall_s     = cand_s && !room_s;
  assign aw_hs_s     = aw_valid_q && m_awready_i;
  assign ar_hs_s     = ar_valid_q && m_arready_i;
  assign pop_s       = aw_hs_s || ar_hs_s;
  assign wq_push_s   = issue_s && head_wr_s;
  assign w_hs_s      = m_wvalid_o && m_wready_i;
  assign w_last_s    = (beat_q == wq_len_s);
  assign wq_pop_s    = w_hs_s && w_last_s;
  assign b_hs_s      = m_bvalid_i && m_bready_o;
  assign r_beat_s    = m_rvalid_i && m_rready_o;
  assign r_done_s    = r_beat_s && m_rlast_i;
  assign b_err_s     = b_hs_s && (m_bresp_i != 2'b00);
  assign r_err_s     = r_beat_s && (m_rresp_i != 2'b00);
  assign start_acc_s = (state_q == ST_IDLE) && start_i;

  // Outstanding count: issue and completions in one cycle give the net change;
  // the result is held within 0..255.
  always_comb begin
    out_sum_s = {1'b0, out_q} + {9'd0, pop_s};
    out_dec_s = {9'd0, b_hs_s} + {9'd0, r_done_s};
    out_net_s = 10'd0;
    if (out_sum_s < out_dec_s) begin
      out_d = 9'd0;
    end else begin
      out_net_s = out_sum_s - out_dec_s;
      if (out_net_s > 10'd255) begin
        out_d = 9'd255;
      end else begin
        out_d = out_net_s[8:0];
      end
    end
  end

  // Next-state logic for the run FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (fifo_empty_s && !pending_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if ((out_q == 9'd0) && wq_empty_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, idle flag and outstanding count registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      idle_q  <= 1'b1;
      out_q   <= 9'd0;
    end else begin
      state_q <= state_d;
      idle_q  <= (state_d == ST_IDLE);
      out_q   <= out_d;
    end
  end

  // Descriptor FIFO storage and pointers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fifo_wr_q <= '0;
      fifo_rd_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
    end else begin
      if (push_ok_s) begin
        fifo_mem_q[fifo_wr_q[FA_W-1:0]] <= {id_i, write_i, axlen_i};
        fifo_wr_q <= fifo_wr_q + 1'b1;
      end
      if (pop_s) begin
        fifo_rd_q <= fifo_rd_q + 1'b1;
      end
    end
  end

  // AW/AR request registers: load on issue, hold until the handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_valid_q <= 1'b0;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= 8'd0;
      ar_valid_q <= 1'b0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= 8'd0;
    end else begin
      if (issue_s && head_wr_s) begin
        aw_valid_q <= 1'b1;
        aw_id_q    <= head_id_s;
        aw_addr_q  <= ADDR_WIDTH'({head_id_s, 8'h00});
        aw_len_q   <= head_len_s;
      end else if (aw_hs_s) begin
        aw_valid_q <= 1'b0;
      end
      if (issue_s && !head_wr_s) begin
        ar_valid_q <= 1'b1;
        ar_id_q    <= head_id_s;
        ar_addr_q  <= ADDR_WIDTH'({head_id_s, 8'h00});
        ar_len_q   <= head_len_s;
      end else if (ar_hs_s) begin
        ar_valid_q <= 1'b0;
      end
    end
  end

  // W queue: filled at write issue so data may lead AW; drained on wlast.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wq_wr_q <= '0;
      wq_rd_q <= '0;
      beat_q  <= 8'd0;
      for (int i = 0; i < WQ_DEPTH; i++) wq_mem_q[i] <= '0;
    end else begin
      if (wq_push_s) begin
        wq_mem_q[wq_wr_q[WA_W-1:0]] <= {head_id_s, head_len_s};
        wq_wr_q <= wq_wr_q + 1'b1;
      end
      if (w_hs_s) begin
        if (w_last_s) begin
          beat_q  <= 8'd0;
          wq_rd_q <= wq_rd_q + 1'b1;
        end else begin
          beat_q  <= beat_q + 8'd1;
        end
      end
    end
  end

  // PMU counter next values; start acceptance clears all but the drop counter.
  always_comb begin
    for (int i = 0; i < NCTR; i++) ctr_d[i] = ctr_q[i];
    ctr_d[0]  = sat_add(ctr_q[0], 64'(!idle_q));
    ctr_d[1]  = sat_add(ctr_q[1], 64'(aw_hs_s));
    ctr_d[2]  = sat_add(ctr_q[2], 64'(ar_hs_s));
    ctr_d[3]  = sat_add(ctr_q[3], 64'(w_hs_s));
    ctr_d[4]  = sat_add(ctr_q[4], 64'(r_beat_s));
    ctr_d[5]  = sat_add(ctr_q[5], 64'(b_hs_s));
    ctr_d[6]  = sat_add(ctr_q[6], 64'(r_done_s));
    ctr_d[7]  = sat_add(ctr_q[7], 64'(stall_s));
    ctr_d[8]  = sat_add(ctr_q[8], 64'(b_err_s) + 64'(r_err_s));
`ifdef LOADER_LATENCY_EN
    if ((state_q == ST_RUN) || (state_q == ST_DRAIN)) begin
      ctr_d[9] = sat_add(ctr_q[9], 64'(out_q));
    end else begin
      ctr_d[9] = ctr_q[9];
    end
    if (64'(out_q) > ctr_q[10]) begin
      ctr_d[10] = 64'(out_q);
    end else begin
      ctr_d[10] = ctr_q[10];
    end
`else
    ctr_d[9]  = 64'd0;
    ctr_d[10] = 64'd0;
`endif
    ctr_d[11] = sat_add(ctr_q[11], 64'(drop_s));
    if (start_acc_s) begin
      for (int i = 0; i < NCTR - 1; i++) ctr_d[i] = 64'd0;
    end else begin
      ctr_d[0] = ctr_d[0];
    end
  end

  // PMU counter registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NCTR; i++) ctr_q[i] <= 64'd0;
    end else begin
      for (int i = 0; i < NCTR; i++) ctr_q[i] <= ctr_d[i];
    end
  end

  // PMU read mux.
  always_comb begin
    pmu_data_o = 64'd0;
    case (pmu_addr_i)
      5'd0:    pmu_data_o = ctr_q[0];
      5'd1:    pmu_data_o = ctr_q[1];
      5'd2:    pmu_data_o = ctr_q[2];
      5'd3:    pmu_data_o = ctr_q[3];
      5'd4:    pmu_data_o = ctr_q[4];
      5'd5:    pmu_data_o = ctr_q[5];
      5'd6:    pmu_data_o = ctr_q[6];
      5'd7:    pmu_data_o = ctr_q[7];
      5'd8:    pmu_data_o = ctr_q[8];
      5'd9:    pmu_data_o = ctr_q[9];
      5'd10:   pmu_data_o = ctr_q[10];
      5'd11:   pmu_data_o = ctr_q[11];
      default: pmu_data_o = 64'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign idle_o      = idle_q;
  assign m_awid_o    = aw_id_q;
  assign m_awaddr_o  = aw_addr_q;
  assign m_awlen_o   = aw_len_q;
  assign m_awsize_o  = 3'($clog2(DATA_WIDTH / 8));
  assign m_awburst_o = 2'b01;
  assign m_awvalid_o = aw_valid_q;
  assign m_arid_o    = ar_id_q;
  assign m_araddr_o  = ar_addr_q;
  assign m_arlen_o   = ar_len_q;
  assign m_arsize_o  = 3'($clog2(DATA_WIDTH / 8));
  assign m_arburst_o = 2'b01;
  assign m_arvalid_o = ar_valid_q;
  assign m_wvalid_o  = !wq_empty_s;
  assign m_wdata_o   = DATA_WIDTH'({wq_id_s, beat_q});
  assign m_wstrb_o   = {(DATA_WIDTH/8){1'b1}};
  assign m_wlast_o   = w_last_s;
  assign m_bready_o  = 1'b1;
  assign m_rready_o  = 1'b1;

endmodule

// File: tb/tb_axi_traffic_loader.sv
module tb_axi_traffic_loader;
  localparam int IDW = 5;
  localparam int DW  = 32;
  localparam int AW  = 16;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [7:0]     req_depth_i = 8'd4;
  logic [IDW-1:0] id_i        = '0;
  logic           write_i     = 1'b0;
  logic [7:0]     axlen_i     = 8'd0;
  logic           fifo_push_i = 1'b0;
  logic           start_i     = 1'b0;
  logic           idle_o;
  logic [4:0]     pmu_addr_i  = 5'd0;
  logic [63:0]    pmu_data_o;

  logic [IDW-1:0] m_awid_o;   logic [AW-1:0] m_awaddr_o; logic [7:0] m_awlen_o;
  logic [2:0]     m_awsize_o; logic [1:0]    m_awburst_o; logic m_awvalid_o;
  logic           m_awready_i = 1'b1;
  logic [DW-1:0]  m_wdata_o;  logic [DW/8-1:0] m_wstrb_o; logic m_wlast_o, m_wvalid_o;
  logic           m_wready_i = 1'b1;
  logic [IDW-1:0] m_bid_i = '0; logic [1:0] m_bresp_i = 2'b00;
  logic           m_bvalid_i = 1'b0; logic m_bready_o;
  logic [IDW-1:0] m_arid_o;   logic [AW-1:0] m_araddr_o; logic [7:0] m_arlen_o;
  logic [2:0]     m_arsize_o; logic [1:0]    m_arburst_o; logic m_arvalid_o;
  logic           m_arready_i = 1'b1;
  logic [IDW-1:0] m_rid_i = '0; logic [DW-1:0] m_rdata_i = '0; logic [1:0] m_rresp_i = 2'b00;
  logic           m_rlast_i = 1'b0, m_rvalid_i = 1'b0; logic m_rready_o;

  axi_traffic_loader dut (
    .aclk(aclk), .aresetn(aresetn), .req_depth_i(req_depth_i), .id_i(id_i),
    .write_i(write_i), .axlen_i(axlen_i), .fifo_push_i(fifo_push_i), .start_i(start_i),
    .idle_o(idle_o), .pmu_addr_i(pmu_addr_i), .pmu_data_o(pmu_data_o),
    .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o), .m_awlen_o(m_awlen_o),
    .m_awsize_o(m_awsize_o), .m_awburst_o(m_awburst_o), .m_awvalid_o(m_awvalid_o),
    .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wlast_o(m_wlast_o),
    .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
    .m_bid_i(m_bid_i), .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
    .m_arid_o(m_arid_o), .m_araddr_o(m_araddr_o), .m_arlen_o(m_arlen_o),
    .m_arsize_o(m_arsize_o), .m_arburst_o(m_arburst_o), .m_arvalid_o(m_arvalid_o),
    .m_arready_i(m_arready_i),
    .m_rid_i(m_rid_i), .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rlast_i(m_rlast_i),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model (acts on the falling edge) ----------------
  logic          r_hold = 1'b0, r_err = 1'b0, w_rdy = 1'b1;
  int            ar_cnt = 0, aw_cnt = 0, r_beats = 0, aw_pend = 0, wl_pend = 0, r_beat = 0;
  logic [AW-1:0] last_araddr = '0, last_awaddr = '0;
  logic [7:0]    last_arlen = '0, last_awlen = '0;
  logic [2:0]    last_awsize = '0;
  logic [1:0]    last_awburst = '0;
  logic [7:0]    rq[$];
  logic [DW-1:0] wlog_data[$];
  logic          wlog_last[$];

  always @(negedge aclk) begin
    if (!aresetn) begin
      m_bvalid_i = 1'b0; m_rvalid_i = 1'b0; m_rlast_i = 1'b0;
      rq.delete(); r_beat = 0; aw_pend = 0; wl_pend = 0;
      m_wready_i = w_rdy;
    end else begin
      m_wready_i = w_rdy;
      // B: a response once both the AW and its last W beat were taken
      m_bvalid_i = 1'b0;
      if (aw_pend > 0 && wl_pend > 0) begin
        m_bvalid_i = 1'b1; aw_pend--; wl_pend--;
      end
      // R: one beat per cycle from the oldest accepted AR
      m_rvalid_i = 1'b0; m_rlast_i = 1'b0;
      if (rq.size() > 0 && !r_hold) begin
        m_rvalid_i = 1'b1;
        m_rdata_i  = DW'(r_beat);
        m_rresp_i  = r_err ? 2'b10 : 2'b00;
        m_rlast_i  = (r_beat == int'(rq[0]));
        r_beats++;
        if (m_rlast_i) begin
          void'(rq.pop_front());
          r_beat = 0;
        end else begin
          r_beat++;
        end
      end
      // record handshakes that complete on the coming rising edge
      if (m_arvalid_o && m_arready_i) begin
        ar_cnt++; last_araddr = m_araddr_o; last_arlen = m_arlen_o;
        rq.push_back(m_arlen_o);
      end
      if (m_awvalid_o && m_awready_i) begin
        aw_cnt++; aw_pend++; last_awaddr = m_awaddr_o; last_awlen = m_awlen_o;
        last_awsize = m_awsize_o; last_awburst = m_awburst_o;
      end
      if (m_wvalid_o && m_wready_i) begin
        wlog_data.push_back(m_wdata_o);
        wlog_last.push_back(m_wlast_o);
        if (m_wlast_o) wl_pend++;
      end
    end
  end

  // ---------------- host tasks ----------------
  task automatic push_desc(input logic [IDW-1:0] id, input logic wr, input logic [7:0] len);
    @(negedge aclk);
    id_i = id; write_i = wr; axlen_i = len; fifo_push_i = 1'b1;
    @(negedge aclk);
    fifo_push_i = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge aclk);
    start_i = 1'b1;
    @(negedge aclk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    while (!idle_o && n < max_cyc) begin
      @(negedge aclk);
      n++;
    end
    check_val(tag, idle_o, 1'b1);
  endtask

  task automatic chk_pmu(input string tag, input logic [4:0] addr, input logic [63:0] exp);
    pmu_addr_i = addr;
    #1;
    check_val(tag, pmu_data_o, exp);
  endtask

  task automatic clear_logs();
    ar_cnt = 0; aw_cnt = 0; r_beats = 0;
    wlog_data.delete(); wlog_last.delete();
  endtask

  initial begin
    int lo_cnt;
    // ---------------- reset state ----------------
    repeat (3) @(negedge aclk);
    #1;
    check_val("rst_idle", idle_o, 1'b1);
    check_val("rst_awvalid", m_awvalid_o, 1'b0);
    check_val("rst_arvalid", m_arvalid_o, 1'b0);
    check_val("rst_wvalid", m_wvalid_o, 1'b0);
    check_val("rst_bready", m_bready_o, 1'b1);
    check_val("rst_rready", m_rready_o, 1'b1);
    chk_pmu("rst_ctr0", 5'd0, 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // ---------------- single read id=3 len=3 ----------------
    clear_logs();
    push_desc(5'd3, 1'b0, 8'd3);
    pulse_start();
    check_val("rd_busy", idle_o, 1'b0);
    wait_idle("rd_done", 100);
    check_val("rd_araddr", last_araddr, 64'h0300);
    check_val("rd_arlen", last_arlen, 64'd3);
    check_val("rd_arcnt", ar_cnt, 64'd1);
    chk_pmu("rd_ctr2", 5'd2, 64'd1);
    chk_pmu("rd_ctr4", 5'd4, 64'd4);
    chk_pmu("rd_ctr6", 5'd6, 64'd1);
    chk_pmu("rd_ctr8", 5'd8, 64'd0);
    chk_pmu("pmu_unmapped", 5'd15, 64'd0);

    // ---------------- single write id=2 len=1, req_depth 0 acts as 1 ----------------
    req_depth_i = 8'd0;
    clear_logs();
    push_desc(5'd2, 1'b1, 8'd1);
    pulse_start();
    wait_idle("wr_done", 100);
    check_val("wr_awaddr", last_awaddr, 64'h0200);
    check_val("wr_awlen", last_awlen, 64'd1);
    check_val("wr_awsize", last_awsize, 64'd2);
    check_val("wr_awburst", last_awburst, 64'd1);
    check_val("wr_wbeats", wlog_data.size(), 64'd2);
    check_val("wr_wdata0", wlog_data[0], 64'h0200);
    check_val("wr_wlast0", wlog_last[0], 1'b0);
    check_val("wr_wdata1", wlog_data[1], 64'h0201);
    check_val("wr_wlast1", wlog_last[1], 1'b1);
    chk_pmu("wr_ctr1", 5'd1, 64'd1);
    chk_pmu("wr_ctr3", 5'd3, 64'd2);
    chk_pmu("wr_ctr5", 5'd5, 64'd1);

    // ---------------- outstanding limit: req_depth=2, R withheld ----------------
    req_depth_i = 8'd2;
    clear_logs();
    for (int i = 1; i <= 4; i++) push_desc(IDW'(i), 1'b0, 8'd0);
    r_hold = 1'b1;
    pulse_start();
    repeat (20) @(negedge aclk);
    check_val("lim_ar_before_r", ar_cnt, 64'd2);
    check_val("lim_no_r_yet", r_beats, 64'd0);
    r_hold = 1'b0;
    wait_idle("lim_done", 200);
    check_val("lim_ar_total", ar_cnt, 64'd4);
    chk_pmu("lim_ctr6", 5'd6, 64'd4);
    pmu_addr_i = 5'd7;
    #1;
    check_val("lim_stall_nz", (pmu_data_o != 64'd0), 1'b1);
`ifdef LOADER_LATENCY_EN
    chk_pmu("lim_peak", 5'd10, 64'd2);
`else
    chk_pmu("lat_ctr9_off", 5'd9, 64'd0);
    chk_pmu("lat_ctr10_off", 5'd10, 64'd0);
`endif

    // ---------------- FIFO overflow: 17 pushes, error responses ----------------
    req_depth_i = 8'd4;
    r_err = 1'b1;
    clear_logs();
    for (int i = 0; i < 17; i++) push_desc(IDW'(i), 1'b0, 8'd0);
    chk_pmu("ovf_drop", 5'd11, 64'd1);
    pulse_start();
    wait_idle("ovf_done", 400);
    r_err = 1'b0;
    check_val("ovf_arcnt", ar_cnt, 64'd16);
    chk_pmu("ovf_ctr2", 5'd2, 64'd16);
    chk_pmu("ovf_ctr8", 5'd8, 64'd16);
    chk_pmu("ovf_drop_kept", 5'd11, 64'd1);

    // ---------------- start with empty FIFO ----------------
    @(negedge aclk);
    start_i = 1'b1;
    @(negedge aclk);
    start_i = 1'b0;
    lo_cnt = 0;
    while (!idle_o && lo_cnt < 10) begin
      lo_cnt++;
      @(negedge aclk);
    end
    check_val("empty_lo_cycles", lo_cnt, 64'd2);
    chk_pmu("empty_ctr0", 5'd0, 64'd2);
    chk_pmu("empty_ctr2_clr", 5'd2, 64'd0);

    // ---------------- start during a run is ignored ----------------
    clear_logs();
    r_hold = 1'b1;
    push_desc(5'd1, 1'b0, 8'd3);
    pulse_start();
    repeat (6) @(negedge aclk);
    pulse_start();
    repeat (2) @(negedge aclk);
    chk_pmu("midstart_ctr2", 5'd2, 64'd1);
    check_val("midstart_busy", idle_o, 1'b0);
    r_hold = 1'b0;
    wait_idle("midstart_done", 100);
    chk_pmu("midstart_ctr4", 5'd4, 64'd4);

    // ---------------- asynchronous reset mid-burst ----------------
    w_rdy = 1'b0;
    push_desc(5'd5, 1'b1, 8'd7);
    pulse_start();
    repeat (4) @(negedge aclk);
    check_val("arst_pre_wvalid", m_wvalid_o, 1'b1);
    #2;
    aresetn = 1'b0;
    #1;
    check_val("arst_awvalid", m_awvalid_o, 1'b0);
    check_val("arst_arvalid", m_arvalid_o, 1'b0);
    check_val("arst_wvalid", m_wvalid_o, 1'b0);
    check_val("arst_idle", idle_o, 1'b1);
    w_rdy = 1'b1;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk_pmu("arst_drop_clr", 5'd11, 64'd0);
    check_val("arst_idle_after", idle_o, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
